spi_phase_sequencer: RTL and testbench

Parametrised successor to the audio board's fixed SPI controller. It sequences the shared SPI bus between the preamp gain programmer, the ADC and the DAC. It adds run/stop control, on-demand gain reprogramming, and rotating DAC channel selection, and it exposes its phase counter. It sits between the clock divider and the gain/ADC/DAC shifters in the multi-effects chain.

---
 rtl/audio_ctrl_pkg.sv | 15 +
 rtl/phase_counter.sv | 26 ++
 rtl/spi_phase_sequencer.sv | 115 +++++++++++
 tb/tb_spi_phase_sequencer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_ctrl_pkg.sv
// Shared types and default phase lengths for the audio board SPI control path.
package audio_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GAIN  = 2'd1,
    GAP   = 2'd2,
    FRAME = 2'd3
  } seq_state_t;

  localparam int GAIN_LEN_DEF  = 8;
  localparam int GAP_LEN_DEF   = 2;
  localparam int FRAME_LEN_DEF = 34;

endpackage

// File: rtl/phase_counter.sv
// Phase counter with synchronous clear; wraps to 0 after reaching a runtime limit.
module phase_counter #(
  parameter int CNT_W = 7
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);

  assign tc = (cnt == limit);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tc ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_phase_sequencer.sv
// Sequences the shared SPI bus between the preamp gain programmer, the ADC and the DAC,
// with run/stop control, on-demand gain reprogramming and rotating DAC channel selection.
module spi_phase_sequencer
  import audio_ctrl_pkg::*;
#(
  parameter int CNT_W      = 7,
  parameter int GAIN_LEN   = GAIN_LEN_DEF,
  parameter int GAP_LEN    = GAP_LEN_DEF,
  parameter int FRAME_LEN  = FRAME_LEN_DEF,
  parameter int NUM_DAC_CH = 4,
  localparam int CH_W      = (NUM_DAC_CH > 1) ? $clog2(NUM_DAC_CH) : 1
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             run,
  input  logic             regain,
  output logic             enablegain,
  output logic             enableadc,
  output logic             enabledac,
  output logic             spissb,
  output logic             sf_ce0,
  output logic             fpgainitb,
  output logic [CNT_W-1:0] contador,
  output logic [CH_W-1:0]  dac_ch,
  output logic             frame_done,
  output logic             busy
);

  localparam logic [CNT_W-1:0] GAIN_LAST  = CNT_W'(GAIN_LEN - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_LEN - 1);
  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] FRAME_PRE  = CNT_W'(FRAME_LEN - 2);
  localparam logic [CH_W-1:0]  CH_LAST    = CH_W'(NUM_DAC_CH - 1);

  seq_state_t       state;
  seq_state_t       state_nx;
  logic             regain_pend;
  logic             regain_hit;
  logic             cnt_clr;
  logic             cnt_tc;
  logic [CNT_W-1:0] cnt_limit;

  assign spissb    = 1'b1;
  assign sf_ce0    = 1'b1;
  assign fpgainitb = 1'b1;

  // A request on the last frame cycle must steer that same boundary, so it is
  // folded into the decision combinationally as well as being latched.
  assign regain_hit = regain && ((state == GAP) || (state == FRAME));

  phase_counter #(
    .CNT_W (CNT_W)
  ) u_phase_counter (
    .clock  (clock),
    .resetn (resetn),
    .clr    (cnt_clr),
    .en     (1'b1),
    .limit  (cnt_limit),
    .cnt    (contador),
    .tc     (cnt_tc)
  );

  always_comb begin
    state_nx  = state;
    cnt_limit = '0;
    cnt_clr   = 1'b0;
    case (state)
      IDLE: begin
        cnt_clr = 1'b1;
        if (run) state_nx = GAIN;
      end
      GAIN: begin
        cnt_limit = GAIN_LAST;
        if (cnt_tc) state_nx = GAP;
      end
      GAP: begin
        cnt_limit = GAP_LAST;
        if (cnt_tc) state_nx = FRAME;
      end
      FRAME: begin
        cnt_limit = FRAME_LAST;
        if (cnt_tc) begin
          if (regain_pend || regain_hit) state_nx = GAIN;
          else if (!run)                 state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      regain_pend <= 1'b0;
      dac_ch      <= '0;
      enablegain  <= 1'b0;
      enableadc   <= 1'b0;
      enabledac   <= 1'b0;
      frame_done  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state <= state_nx;
      if ((state_nx == GAIN) && (state != GAIN)) regain_pend <= 1'b0;
      else if (regain_hit)                       regain_pend <= 1'b1;
      if ((state == FRAME) && cnt_tc) dac_ch <= (dac_ch == CH_LAST) ? '0 : dac_ch + 1'b1;
      enablegain <= (state_nx == GAIN);
      enableadc  <= (state_nx == FRAME);
      enabledac  <= (state_nx == FRAME);
      busy       <= (state_nx != IDLE);
      // Registered one cycle ahead; FRAME_LEN >= 2 keeps the pre-last cycle inside the frame.
      frame_done <= (state == FRAME) && (contador == FRAME_PRE);
    end
  end

endmodule

// File: tb/tb_spi_phase_sequencer.sv
// Scoreboard bench for spi_phase_sequencer: default parameter set plus a narrow
// single-channel set, both driven by the same stimulus and checked every cycle.
module tb_spi_phase_sequencer;

  localparam int GL  = 8;
  localparam int PL  = 2;
  localparam int FLA = 34;
  localparam int NCA = 4;
  localparam int FLB = 16;
  localparam int NCB = 1;

  localparam int M_IDLE  = 0;
  localparam int M_GAIN  = 1;
  localparam int M_GAP   = 2;
  localparam int M_FRAME = 3;

  typedef struct packed {
    logic       g;
    logic       a;
    logic       d;
    logic [7:0] cnt;
    logic [3:0] ch;
    logic       fd;
    logic       busy;
    logic       ssb;
    logic       ce0;
    logic       initb;
  } obs_t;

  typedef struct {
    int mode;
    int pos;
    int ch;
    bit pend;
  } mdl_t;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  logic run = 1'b0;
  logic regain = 1'b0;

  logic       ga, aa, da, sa, ca, ia, fda, ba;
  logic [6:0] cnta;
  logic [1:0] cha;
  logic       gb, ab, db, sb, cb, ib, fdb, bb;
  logic [3:0] cntb;
  logic [0:0] chb;

  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  spi_phase_sequencer #(
    .CNT_W(7), .GAIN_LEN(GL), .GAP_LEN(PL), .FRAME_LEN(FLA), .NUM_DAC_CH(NCA)
  ) dut_a (
    .clock(clock), .resetn(resetn), .run(run), .regain(regain),
    .enablegain(ga), .enableadc(aa), .enabledac(da),
    .spissb(sa), .sf_ce0(ca), .fpgainitb(ia),
    .contador(cnta), .dac_ch(cha), .frame_done(fda), .busy(ba)
  );

  spi_phase_sequencer #(
    .CNT_W(4), .GAIN_LEN(GL), .GAP_LEN(PL), .FRAME_LEN(FLB), .NUM_DAC_CH(NCB)
  ) dut_b (
    .clock(clock), .resetn(resetn), .run(run), .regain(regain),
    .enablegain(gb), .enableadc(ab), .enabledac(db),
    .spissb(sb), .sf_ce0(cb), .fpgainitb(ib),
    .contador(cntb), .dac_ch(chb), .frame_done(fdb), .busy(bb)
  );

  obs_t oa, ob;
  assign oa = {ga, aa, da, 8'(cnta), 4'(cha), fda, ba, sa, ca, ia};
  assign ob = {gb, ab, db, 8'(cntb), 4'(chb), fdb, bb, sb, cb, ib};

  // Reference model: a phase name, a position inside it, the phase lengths,
  // and the channel as a modulo count.
  function automatic mdl_t mdl_init();
    mdl_t m;
    m.mode = M_IDLE;
    m.pos  = 0;
    m.ch   = 0;
    m.pend = 1'b0;
    return m;
  endfunction

  function automatic mdl_t mdl_step(input mdl_t m, input bit r, input bit rg,
                                    input int flen, input int nch);
    mdl_t n;
    bit   hit;
    int   len;
    n   = m;
    hit = rg && (m.mode == M_GAP || m.mode == M_FRAME);
    len = (m.mode == M_GAIN) ? GL : (m.mode == M_GAP) ? PL : flen;
    if (m.mode == M_IDLE) begin
      if (r) n.mode = M_GAIN;
    end else if (m.pos < len - 1) begin
      n.pos = m.pos + 1;
    end else begin
      n.pos = 0;
      if (m.mode == M_GAIN)     n.mode = M_GAP;
      else if (m.mode == M_GAP) n.mode = M_FRAME;
      else begin
        n.ch = (m.ch + 1) % nch;
        if (m.pend || hit) n.mode = M_GAIN;
        else if (!r)       n.mode = M_IDLE;
      end
    end
    if (n.mode == M_GAIN && m.mode != M_GAIN) n.pend = 1'b0;
    else if (hit)                             n.pend = 1'b1;
    return n;
  endfunction

  function automatic obs_t mdl_obs(input mdl_t m, input int flen);
    obs_t o;
    o.g     = (m.mode == M_GAIN);
    o.a     = (m.mode == M_FRAME);
    o.d     = (m.mode == M_FRAME);
    o.cnt   = 8'(m.pos);
    o.ch    = 4'(m.ch);
    o.fd    = (m.mode == M_FRAME) && (m.pos == flen - 1);
    o.busy  = (m.mode != M_IDLE);
    o.ssb   = 1'b1;
    o.ce0   = 1'b1;
    o.initb = 1'b1;
    return o;
  endfunction

  mdl_t ma = mdl_init();
  mdl_t mb = mdl_init();
  obs_t qa[$];
  obs_t qb[$];
  obs_t ea, eb;

  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      ma = mdl_init();
      mb = mdl_init();
      qa.delete();
      qb.delete();
    end else begin
      ma = mdl_step(ma, run, regain, FLA, NCA);
      mb = mdl_step(mb, run, regain, FLB, NCB);
    end
    qa.push_back(mdl_obs(ma, FLA));
    qb.push_back(mdl_obs(mb, FLB));
  end

  task automatic check(input string nm, input obs_t got, input obs_t exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s t=%0t got=%h exp=%h (cnt %0d/%0d ch %0d/%0d busy %0b/%0b)",
               nm, $time, got, exp, got.cnt, exp.cnt, got.ch, exp.ch, got.busy, exp.busy);
    end
  endtask

  task automatic cmp_int(input string nm, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s t=%0t got=%0d exp=%0d", nm, $time, got, exp);
    end
  endtask

  always @(negedge clock) begin
    if (qa.size() > 0) begin
      ea = qa.pop_front();
      check("setA", oa, ea);
    end
    if (qb.size() > 0) begin
      eb = qb.pop_front();
      check("setB", ob, eb);
    end
  end

  task automatic tick(input int k);
    repeat (k) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic wait_a(input int mode, input int pos, input int budget);
    int n;
    n = 0;
    do begin
      tick(1);
      n++;
    end while (!(ma.mode == mode && ma.pos == pos) && n < budget);
    if (!(ma.mode == mode && ma.pos == pos)) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_phase t=%0t got=%0d/%0d exp=%0d/%0d", $time, ma.mode, ma.pos, mode, pos);
    end
  endtask

  task automatic rst_check(input string nm);
    mdl_t z;
    z = mdl_init();
    check({nm, "_A"}, oa, mdl_obs(z, FLA));
    check({nm, "_B"}, ob, mdl_obs(z, FLB));
  endtask

  initial begin
    int n;
    tick(3);
    rst_check("reset");
    resetn = 1'b1;
    tick(1);

    run = 1'b1;
    n = 0;
    do begin
      tick(1);
      n++;
    end while (!aa && n < 100);
    cmp_int("first_adc_latency", n, GL + PL + 1);

    wait_a(M_FRAME, FLA - 1, 200);
    n = 0;
    do begin
      tick(1);
      n++;
    end while (!fda && n < 100);
    cmp_int("frame_period", n, FLA);
    tick(4 * FLA);

    wait_a(M_FRAME, 5, 100);
    regain = 1'b1;
    tick(1);
    regain = 1'b0;
    wait_a(M_GAIN, 2, 100);
    regain = 1'b1;
    tick(1);
    regain = 1'b0;
    wait_a(M_FRAME, FLA - 1, 200);
    regain = 1'b1;
    tick(1);
    regain = 1'b0;
    cmp_int("regain_last_cycle_gain", int'(ga), 1);

    wait_a(M_FRAME, 10, 200);
    run = 1'b0;
    wait_a(M_FRAME, FLA - 1, 100);
    tick(1);
    cmp_int("stop_busy", int'(ba), 0);
    regain = 1'b1;
    tick(1);
    regain = 1'b0;
    tick(3);

    run = 1'b1;
    wait_a(M_FRAME, 20, 200);
    #2;
    resetn = 1'b0;
    #1;
    rst_check("async_reset");
    tick(2);
    resetn = 1'b1;

    for (int i = 0; i < 3000; i++) begin
      tick(1);
      if ($urandom_range(0, 99) < 3) run = ~run;
      regain = ($urandom_range(0, 39) == 0);
    end

    run = 1'b0;
    regain = 1'b0;
    tick(100);
    cmp_int("final_idle_busy", int'(ba), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
